// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronized input, mid-bit sampling timed from the
// detected start edge, registered data/valid/busy/framing-error outputs.
module uart_rx #(
  parameter int unsigned CLK_FREQ_HZ = 100000000,
  parameter int unsigned BAUD_RATE   = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int unsigned CNT_W        = 16;
  localparam int unsigned DATA_W       = 8;
  localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    STOP_BIT,
    CLEANUP
  } state_e;

  logic              sync1_q, sync2_q;
  logic              rx_s;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              rx_busy_q, rx_busy_d;
  logic              frame_err_q, frame_err_d;

  assign rx_s = sync2_q;

  // Metastability guard; resets to the idle-high line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_busy_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_busy_q   <= rx_busy_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (!rx_s) state_d = START_BIT;
      end
      // Half a bit in: a line back high here was only a glitch.
      START_BIT: begin
        if (cnt_q == CNT_HALF_END) begin
          cnt_d   = '0;
          state_d = rx_s ? IDLE : DATA_BITS;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA_BITS: begin
        if (cnt_q == CNT_BIT_END) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
            state_d   = STOP_BIT;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP_BIT: begin
        if (cnt_q == CNT_BIT_END) begin
          cnt_d   = '0;
          state_d = CLEANUP;
          if (rx_s) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // Wait out a held-low line so a break yields a single error.
      CLEANUP: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    rx_busy_d = (state_d != IDLE);
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_busy   = rx_busy_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx at 16 clocks per bit: frames are
// serialized from bytes, expected results queued, and a monitor checks each pulse.
module tb_uart_rx;

  localparam int unsigned CLK_FREQ_HZ = 1600;
  localparam int unsigned BAUD_RATE   = 100;
  localparam int          P           = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  int         n_vec  = 0;
  int         n_fail = 0;
  logic [7:0] last_good = 8'h00;

  uart_rx #(.CLK_FREQ_HZ(CLK_FREQ_HZ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_busy  (rx_busy),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Frame = start(0), data LSB first, stop; each bit held p clocks.
  task automatic send(input logic [7:0] d, input bit stop_ok, input int p);
    logic [9:0] frame;
    exp_t       e;
    frame = {stop_ok, d, 1'b0};
    if (stop_ok) begin
      last_good = d;
      e.is_err  = 1'b0;
      e.data    = d;
    end else begin
      e.is_err = 1'b1;
      e.data   = last_good;
    end
    exp_q.push_back(e);
    for (int i = 0; i < 10; i++) begin
      rx = frame[i];
      repeat (p) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && (rx_valid || frame_err)) begin
      check("valid_ferr_exclusive", 32'(rx_valid & frame_err), 0);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_pulse: valid=%b ferr=%b data=0x%h, nothing expected",
                 rx_valid, frame_err, rx_data);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind_is_err", 32'(frame_err), 32'(e.is_err));
        check("rx_data", 32'(rx_data), 32'(e.data));
      end
    end
  end

  initial begin
    int         bc;
    int         gap;
    bit         ok;
    logic [7:0] d;
    logic [7:0] b81;

    repeat (3) @(negedge clk);
    check("reset_rx_data", 32'(rx_data), 0);
    check("reset_rx_valid", 32'(rx_valid), 0);
    check("reset_rx_busy", 32'(rx_busy), 0);
    check("reset_frame_err", 32'(frame_err), 0);
    rst_n = 1'b1;
    idle(20);

    // Single clean frame
    send(8'hA5, 1'b1, P);
    idle(8);
    check("busy_after_a5", 32'(rx_busy), 0);
    check("hold_a5", 32'(rx_data), 32'hA5);

    // Back-to-back frames
    send(8'h00, 1'b1, P);
    send(8'hFF, 1'b1, P);
    send(8'h3C, 1'b1, P);
    idle(32);
    check("hold_3c", 32'(rx_data), 32'h3C);

    // 4-cycle glitch: false start
    bc = 0;
    rx = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rx_busy) bc++;
    end
    rx = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rx_busy) bc++;
    end
    n_vec++;
    if (bc < 1 || bc > 10) begin
      n_fail++;
      $display("FAIL glitch_busy: busy for %0d cycles, required 1..10", bc);
    end

    // Bad stop bit followed by a 64-cycle break
    send(8'h55, 1'b0, P);
    rx = 1'b0;
    repeat (64) @(negedge clk);
    check("busy_during_break", 32'(rx_busy), 1);
    check("data_kept_after_ferr", 32'(rx_data), 32'h3C);
    idle(8);
    check("busy_after_break", 32'(rx_busy), 0);
    send(8'h12, 1'b1, P);
    idle(32);
    check("hold_12", 32'(rx_data), 32'h12);

    // Reset during data bit 3 of 0x81
    b81 = 8'h81;
    rx = 1'b0;
    repeat (P) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = b81[i];
      repeat (P) @(negedge clk);
    end
    rx = b81[3];
    repeat (P / 2) @(negedge clk);
    check("busy_mid_frame", 32'(rx_busy), 1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_rx_data", 32'(rx_data), 0);
    check("abort_rx_valid", 32'(rx_valid), 0);
    check("abort_rx_busy", 32'(rx_busy), 0);
    check("abort_frame_err", 32'(frame_err), 0);
    last_good = 8'h00;
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    idle(40);
    send(8'h7E, 1'b1, P);
    idle(32);
    check("hold_7e", 32'(rx_data), 32'h7E);

    // Baud mismatch tolerance
    send(8'hC3, 1'b1, 15);
    idle(40);
    send(8'hC3, 1'b1, 17);
    idle(40);
    check("hold_c3", 32'(rx_data), 32'hC3);

    // Random traffic, some back-to-back, some with bad stop bits
    for (int n = 0; n < 24; n++) begin
      d   = 8'($urandom);
      ok  = ($urandom_range(0, 5) != 0);
      gap = int'($urandom_range(0, 20));
      if (!ok && gap < 8) gap = 8;
      send(d, ok, P);
      idle(gap);
    end
    idle(200);
    check("final_busy", 32'(rx_busy), 0);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_pulses: %0d expected results never seen, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
